wb_port_scheduler: RTL

WB_PORT_SCHEDULER -- requirements
Module: wb_port_scheduler

---
 rtl/wb_sched_pkg.sv | 44 ++++
 rtl/wb_slot_table.sv | 43 ++++
 rtl/wb_port_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/wb_sched_pkg.sv
// Shared types and constants for the writeback port scheduler: FU ids,
// fixed FU latencies and the reservation slot entry.
package wb_sched_pkg;

    localparam int unsigned FU_W           = 3;
    localparam int unsigned REG_W          = 5;
    localparam int unsigned LAT_W          = 5;
    localparam int unsigned DEPTH_DEFAULT  = 32;
    localparam int unsigned NUM_FU_DEFAULT = 5;

    typedef enum logic [FU_W-1:0] {
        FU_NONE = 3'd0,
        FU_ALU  = 3'd1,
        FU_MEM  = 3'd2,
        FU_MUL  = 3'd3,
        FU_DIV  = 3'd4,
        FU_JUMP = 3'd5
    } fu_e;

    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_MEM  = 2;
    localparam int unsigned LAT_MUL  = 7;
    localparam int unsigned LAT_DIV  = 24;
    localparam int unsigned LAT_JUMP = 2;

    typedef struct packed {
        logic [FU_W-1:0]  fu;
        logic [REG_W-1:0] rd;
        logic             we;
    } slot_t;

    // Zero marks an id with no execution unit behind it.
    function automatic logic [LAT_W-1:0] fu_latency(input logic [FU_W-1:0] fu);
        case (fu)
            FU_ALU:  return LAT_W'(LAT_ALU);
            FU_MEM:  return LAT_W'(LAT_MEM);
            FU_MUL:  return LAT_W'(LAT_MUL);
            FU_DIV:  return LAT_W'(LAT_DIV);
            FU_JUMP: return LAT_W'(LAT_JUMP);
            default: return LAT_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/wb_slot_table.sv
// Writeback reservation table: shifts one slot toward slot 0 every cycle,
// with a single insert port addressing the post-shift position.
module wb_slot_table
    import wb_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             insert_en,
    input  logic [LAT_W-1:0] insert_pos,
    input  slot_t            insert_entry,
    output slot_t            slots [DEPTH]
);

    slot_t slot_q [DEPTH];
    slot_t slot_d [DEPTH];

    always_comb begin
        slot_d[DEPTH-1] = '0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            slot_d[i] = slot_q[i+1];
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (insert_en && int'(insert_pos) == i) begin
                slot_d[i] = insert_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slots = slot_q;

endmodule

// File: rtl/wb_port_scheduler.sv
// Single-writeback-port scheduler: issues only when the result slot is free,
// the FU is idle and no register hazard exists against in-flight entries.
module wb_port_scheduler
    import wb_sched_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned NUM_FU = NUM_FU_DEFAULT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [FU_W-1:0]   issue_fu,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [REG_W-1:0]  issue_rs1,
    input  logic [REG_W-1:0]  issue_rs2,
    input  logic              issue_we,
    input  logic              flush,
    output logic              issue_ready,
    output logic              wb_valid,
    output logic [FU_W-1:0]   wb_sel,
    output logic [REG_W-1:0]  wb_rd,
    output logic [NUM_FU-1:0] fu_busy
);

    slot_t            slots [DEPTH];
    slot_t            head;
    slot_t            insert_entry;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] insert_pos;
    logic             fu_known;
    logic             busy_hit;
    logic             port_conflict;
    logic             data_hazard;
    logic             accept;

    assign head = slots[0];

    // Hazard evaluation against the pre-shift table; slot 0 still counts as in flight.
    always_comb begin
        lat           = fu_latency(issue_fu);
        fu_known      = (issue_fu != '0) && (int'(issue_fu) <= int'(NUM_FU));
        busy_hit      = 1'b0;
        port_conflict = (lat == '0) || (int'(lat) > int'(DEPTH));
        data_hazard   = 1'b0;
        for (int f = 0; f < int'(NUM_FU); f++) begin
            if (int'(issue_fu) == f + 1) begin
                busy_hit = fu_busy[f];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (int'(lat) == i && slots[i].fu != '0) begin
                port_conflict = 1'b1;
            end
            if (slots[i].fu != '0 && slots[i].we && slots[i].rd != '0) begin
                if (slots[i].rd == issue_rs1 || slots[i].rd == issue_rs2) begin
                    data_hazard = 1'b1;
                end
                if (issue_we && slots[i].rd == issue_rd) begin
                    data_hazard = 1'b1;
                end
            end
        end
    end

    // FU id 0 never touches the table, so it is only held off by flush.
    always_comb begin
        issue_ready = 1'b0;
        if (!flush) begin
            if (issue_fu == '0) begin
                issue_ready = 1'b1;
            end else begin
                issue_ready = fu_known && !(busy_hit && head.fu != issue_fu) &&
                              !port_conflict && !data_hazard;
            end
        end
    end

    assign accept       = issue_valid && issue_ready && (issue_fu != '0);
    assign insert_pos   = lat - LAT_W'(1);
    assign insert_entry = '{fu: issue_fu, rd: issue_rd, we: issue_we};

    wb_slot_table #(.DEPTH(DEPTH)) u_table (
        .clk          (clk),
        .rst          (rst),
        .insert_en    (accept),
        .insert_pos   (insert_pos),
        .insert_entry (insert_entry),
        .slots        (slots)
    );

    // A new accept to an FU overrides the clear from its retiring entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fu_busy <= '0;
        end else begin
            for (int f = 0; f < int'(NUM_FU); f++) begin
                if (accept && int'(issue_fu) == f + 1) begin
                    fu_busy[f] <= 1'b1;
                end else if (int'(head.fu) == f + 1) begin
                    fu_busy[f] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_sel   <= '0;
            wb_rd    <= '0;
        end else begin
            wb_valid <= (head.fu != '0) && head.we && (head.rd != '0);
            wb_sel   <= head.fu;
            wb_rd    <= head.rd;
        end
    end

endmodule
